// File: rtl/operand2_fetch_seq_pkg.sv
// Shared constants for the operand-2 path: CTRL_select encodings, instruction field
// positions, the fetch-sequencer state enum and the decoded-field payload.
package operand2_fetch_seq_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned RADDR_W_DEF = 4;
  localparam int unsigned INSTR_W     = 32;

  localparam logic [2:0] SEL_DP_REG  = 3'b000;
  localparam logic [2:0] SEL_DP_IMM  = 3'b001;
  localparam logic [2:0] SEL_MEM_IMM = 3'b010;
  localparam logic [2:0] SEL_MEM_REG = 3'b011;
  localparam logic [2:0] SEL_BRANCH  = 3'b101;

  // {instr[27:26], instr[25]} is the contiguous slice instr[27:25]
  localparam int unsigned SEL_LSB   = 25;
  localparam int unsigned RN_LSB    = 16;
  localparam int unsigned RD_LSB    = 12;
  localparam int unsigned RS_LSB    = 8;
  localparam int unsigned ROT_LSB   = 8;
  localparam int unsigned SHAMT_LSB = 7;
  localparam int unsigned SH_LSB    = 5;
  localparam int unsigned BIT4_POS  = 4;
  localparam int unsigned RM_LSB    = 0;
  localparam int unsigned IMM_W     = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    CAP_A = 3'd2,
    CAP_S = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic [2:0]       sel;
    logic [4:0]       shamt5;
    logic [3:0]       rot;
    logic [1:0]       sh;
    logic             bit4;
    logic [IMM_W-1:0] imm;
    logic [3:0]       rd;
    logic [3:0]       rn;
    logic [3:0]       rm;
    logic [3:0]       rs;
    logic             illegal;
    logic             needs_rs;
  } fields_t;

endpackage

// File: rtl/operand2_fetch_seq_if.sv
// Instruction, register-file and operand-bundle signals of operand2_fetch_seq.
// OPDEC_PC_FORWARD_EN adds the pc input.
interface operand2_fetch_seq_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 4
);
  logic               instr_valid;
  logic               instr_ready;
  logic [31:0]        instr;
  logic [RADDR_W-1:0] rf_addr_a;
  logic [RADDR_W-1:0] rf_addr_b;
  logic [DATA_W-1:0]  rf_data_a;
  logic [DATA_W-1:0]  rf_data_b;
  logic [2:0]         CTRL_select;
  logic [4:0]         IR_shamt5;
  logic [3:0]         IR_rot;
  logic [1:0]         IR_sh;
  logic               IR_4th;
  logic [23:0]        IR_imm;
  logic [3:0]         IR_rd;
  logic [DATA_W-1:0]  RF_Rm;
  logic [DATA_W-1:0]  RF_Rs;
  logic [DATA_W-1:0]  Rn_val;
  logic               op_illegal;
  logic               op_valid;
  logic               op_ready;
`ifdef OPDEC_PC_FORWARD_EN
  logic [DATA_W-1:0]  pc;
`endif

  modport master (
    input  instr_valid, instr, rf_data_a, rf_data_b, op_ready,
`ifdef OPDEC_PC_FORWARD_EN
    input  pc,
`endif
    output instr_ready, rf_addr_a, rf_addr_b, CTRL_select, IR_shamt5, IR_rot, IR_sh,
           IR_4th, IR_imm, IR_rd, RF_Rm, RF_Rs, Rn_val, op_illegal, op_valid
  );

  modport slave (
    output instr_valid, instr, rf_data_a, rf_data_b, op_ready,
`ifdef OPDEC_PC_FORWARD_EN
    output pc,
`endif
    input  instr_ready, rf_addr_a, rf_addr_b, CTRL_select, IR_shamt5, IR_rot, IR_sh,
           IR_4th, IR_imm, IR_rd, RF_Rm, RF_Rs, Rn_val, op_illegal, op_valid
  );
endinterface

// File: rtl/operand2_fetch_seq_instr_field_decode.sv
// Combinational split of an instruction word into shifter fields, plus
// illegal-opcode and register-shift (Rs read needed) flags.
module operand2_fetch_seq_instr_field_decode
  import operand2_fetch_seq_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output fields_t            fields_c
);

  logic unused_cond_c;
  assign unused_cond_c = ^instr[INSTR_W-1:28];

  always_comb begin
    fields_c          = '0;
    fields_c.sel      = instr[SEL_LSB +: 3];
    fields_c.shamt5   = instr[SHAMT_LSB +: 5];
    fields_c.rot      = instr[ROT_LSB +: 4];
    fields_c.sh       = instr[SH_LSB +: 2];
    fields_c.bit4     = instr[BIT4_POS];
    fields_c.imm      = instr[IMM_W-1:0];
    fields_c.rd       = instr[RD_LSB +: 4];
    fields_c.rn       = instr[RN_LSB +: 4];
    fields_c.rm       = instr[RM_LSB +: 4];
    fields_c.rs       = instr[RS_LSB +: 4];
    fields_c.illegal  = !(fields_c.sel inside {SEL_DP_REG, SEL_DP_IMM, SEL_MEM_IMM,
                                               SEL_MEM_REG, SEL_BRANCH});
    fields_c.needs_rs = (fields_c.sel == SEL_DP_REG) && fields_c.bit4;
  end

endmodule

// File: rtl/operand2_fetch_seq.sv
// Operand-2 fetch sequencer: decodes an instruction, reads Rn/Rm (and Rs for register
// shifts) over two synchronous RF ports, presents a valid/ready bundle.
// Optional build macro OPDEC_PC_FORWARD_EN replaces R15 reads with pc+8.
module operand2_fetch_seq
  import operand2_fetch_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RADDR_W = RADDR_W_DEF
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  operand2_fetch_seq_if.master bus
);

  state_e             state_q, state_d;
  fields_t            ir_q, ir_d, dec_c;
  logic [DATA_W-1:0]  rn_q, rn_d, rm_q, rm_d, rs_q, rs_d;
  logic [RADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic               op_valid_q, op_valid_d;
  logic [DATA_W-1:0]  rn_src_c, rm_src_c, rs_src_c;

  operand2_fetch_seq_instr_field_decode u_decode (
    .instr    (bus.instr),
    .fields_c (dec_c)
  );

  // Captured values; R15 optionally forwards pc+8 sampled in the capture cycle
`ifdef OPDEC_PC_FORWARD_EN
  logic [DATA_W-1:0] pc_plus8_c;
  assign pc_plus8_c = bus.pc + DATA_W'(8);
  assign rn_src_c   = (ir_q.rn == 4'hF) ? pc_plus8_c : bus.rf_data_a;
  assign rm_src_c   = (ir_q.rm == 4'hF) ? pc_plus8_c : bus.rf_data_b;
  assign rs_src_c   = (ir_q.rs == 4'hF) ? pc_plus8_c : bus.rf_data_a;
`else
  logic unused_src_c;
  assign unused_src_c = ^{ir_q.rn, ir_q.rm};
  assign rn_src_c     = bus.rf_data_a;
  assign rm_src_c     = bus.rf_data_b;
  assign rs_src_c     = bus.rf_data_a;
`endif

  // Addresses are registered one cycle ahead so they are valid in RD_A and CAP_A
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    rs_d     = rs_q;
    addr_a_d = '0;
    addr_b_d = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          ir_d = dec_c;
          rn_d = '0;
          rm_d = '0;
          rs_d = '0;
          if (dec_c.illegal || (dec_c.sel == SEL_BRANCH)) begin
            state_d = DONE;
          end else begin
            state_d  = RD_A;
            addr_a_d = RADDR_W'(dec_c.rn);
            addr_b_d = RADDR_W'(dec_c.rm);
          end
        end
      end
      RD_A: begin
        state_d = CAP_A;
        if (ir_q.needs_rs) addr_a_d = RADDR_W'(ir_q.rs);
      end
      CAP_A: begin
        rn_d = rn_src_c;
        rm_d = rm_src_c;
        if (ir_q.needs_rs) begin
          state_d = CAP_S;
        end else begin
          rs_d    = '0;
          state_d = DONE;
        end
      end
      CAP_S: begin
        rs_d    = rs_src_c;
        state_d = DONE;
      end
      DONE: begin
        if (bus.op_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    op_valid_d = (state_d == DONE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q    <= IDLE;
      ir_q       <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      rs_q       <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      rn_q       <= rn_d;
      rm_q       <= rm_d;
      rs_q       <= rs_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign bus.instr_ready = (state_q == IDLE) && !RESET;
  assign bus.rf_addr_a   = addr_a_q;
  assign bus.rf_addr_b   = addr_b_q;
  assign bus.CTRL_select = ir_q.sel;
  assign bus.IR_shamt5   = ir_q.shamt5;
  assign bus.IR_rot      = ir_q.rot;
  assign bus.IR_sh       = ir_q.sh;
  assign bus.IR_4th      = ir_q.bit4;
  assign bus.IR_imm      = ir_q.imm;
  assign bus.IR_rd       = ir_q.rd;
  assign bus.Rn_val      = rn_q;
  assign bus.RF_Rm       = rm_q;
  assign bus.RF_Rs       = rs_q;
  assign bus.op_illegal  = ir_q.illegal;
  assign bus.op_valid    = op_valid_q;

endmodule

// File: tb/tb_operand2_fetch_seq.sv
// Bench for operand2_fetch_seq: directed plan items plus randomized instructions
// checked against a field/register reference model and a synchronous RF model.
module tb_operand2_fetch_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand2_fetch_seq_if bus ();

  operand2_fetch_seq dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus.master)
  );

  logic [31:0] regs [16];
`ifdef OPDEC_PC_FORWARD_EN
  logic [31:0] pc_v;
  assign bus.pc = pc_v;
`endif

  // Register file with one-cycle synchronous read on both ports
  always @(posedge clk) begin
    bus.rf_data_a <= regs[bus.rf_addr_a];
    bus.rf_data_b <= regs[bus.rf_addr_b];
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [4:0]  shamt5;
    logic [3:0]  rot;
    logic [1:0]  sh;
    logic        b4;
    logic [23:0] imm;
    logic [3:0]  rd;
    logic [3:0]  rn_a, rm_a, rs_a;
    logic [31:0] rn_val, rm_val, rs_val;
    logic        ill, skip, nrs;
    int          lat;
  } exp_t;

  function automatic logic [31:0] rval(input logic [3:0] a);
`ifdef OPDEC_PC_FORWARD_EN
    if (a == 4'hF) return pc_v + 32'd8;
`endif
    return regs[a];
  endfunction

  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    e.sel    = ins[27:25];
    e.shamt5 = ins[11:7];
    e.rot    = ins[11:8];
    e.sh     = ins[6:5];
    e.b4     = ins[4];
    e.imm    = ins[23:0];
    e.rd     = ins[15:12];
    e.rn_a   = ins[19:16];
    e.rm_a   = ins[3:0];
    e.rs_a   = ins[11:8];
    e.ill    = (e.sel == 3'd4) || (e.sel == 3'd6) || (e.sel == 3'd7);
    e.skip   = e.ill || (e.sel == 3'd5);
    e.nrs    = (e.sel == 3'd0) && e.b4;
    e.rn_val = e.skip ? 32'd0 : rval(e.rn_a);
    e.rm_val = e.skip ? 32'd0 : rval(e.rm_a);
    e.rs_val = e.nrs ? rval(e.rs_a) : 32'd0;
    e.lat    = e.skip ? 1 : (e.nrs ? 4 : 3);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bundle(input exp_t e);
    chk("op_valid",    32'(bus.op_valid), 32'd1);
    chk("instr_ready", 32'(bus.instr_ready), 32'd0);
    chk("ctrl_select", 32'(bus.CTRL_select), 32'(e.sel));
    chk("ir_shamt5",   32'(bus.IR_shamt5), 32'(e.shamt5));
    chk("ir_rot",      32'(bus.IR_rot), 32'(e.rot));
    chk("ir_sh",       32'(bus.IR_sh), 32'(e.sh));
    chk("ir_4th",      32'(bus.IR_4th), 32'(e.b4));
    chk("ir_imm",      32'(bus.IR_imm), 32'(e.imm));
    chk("ir_rd",       32'(bus.IR_rd), 32'(e.rd));
    chk("rn_val",      bus.Rn_val, e.rn_val);
    chk("rf_rm",       bus.RF_Rm, e.rm_val);
    chk("rf_rs",       bus.RF_Rs, e.rs_val);
    chk("op_illegal",  32'(bus.op_illegal), 32'(e.ill));
    chk("done_addr_a", 32'(bus.rf_addr_a), 32'd0);
    chk("done_addr_b", 32'(bus.rf_addr_b), 32'd0);
  endtask

  // Entered and left at a negedge with the DUT idle, so back-to-back calls
  // exercise acceptance in the cycle right after a handshake.
  task automatic run_txn(input logic [31:0] ins, input int hold);
    exp_t e;
    int   lat;
    e = model(ins);
    chk("accept_ready", 32'(bus.instr_ready), 32'd1);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    bus.op_ready    = 1'b0;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    lat = 1;
    while ((bus.op_valid !== 1'b1) && (lat < 8)) begin
      if (lat == 1) begin
        chk("rd_addr_a", 32'(bus.rf_addr_a), 32'(e.rn_a));
        chk("rd_addr_b", 32'(bus.rf_addr_b), 32'(e.rm_a));
      end else if (lat == 2) begin
        chk("cap_addr_a", 32'(bus.rf_addr_a), e.nrs ? 32'(e.rs_a) : 32'd0);
        chk("cap_addr_b", 32'(bus.rf_addr_b), 32'd0);
      end else begin
        chk("caps_addr_a", 32'(bus.rf_addr_a), 32'd0);
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(e.lat));
    chk_bundle(e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk_bundle(e);
    end
    bus.op_ready = 1'b1;
    @(negedge clk);
    bus.op_ready = 1'b0;
    chk("post_hs_valid", 32'(bus.op_valid), 32'd0);
    chk("post_hs_ready", 32'(bus.instr_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
`ifdef OPDEC_PC_FORWARD_EN
    pc_v = 32'h0000_1000;
`endif
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    bus.op_ready    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("rst_ready",    32'(bus.instr_ready), 32'd0);
    chk("rst_addr_a",   32'(bus.rf_addr_a), 32'd0);
    chk("rst_rn",       bus.Rn_val, 32'd0);
    chk("rst_sel",      32'(bus.CTRL_select), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", 32'(bus.instr_ready), 32'd1);
    @(negedge clk);

    // Data-processing, immediate shift
    regs[2] = 32'd5;
    regs[3] = 32'd8;
    run_txn(32'hE082_1103, 0);
    chk("t1_shamt", 32'(bus.IR_shamt5), 32'd2);
    chk("t1_rn",    bus.Rn_val, 32'd5);
    chk("t1_rm",    bus.RF_Rm, 32'd8);

    // Register-specified shift needs the Rs read
    regs[3] = 32'hFFFF_FFFC;
    regs[4] = 32'd4;
    run_txn(32'hE082_1453, 0);
    chk("t2_sh", 32'(bus.IR_sh), 32'd2);
    chk("t2_rm", bus.RF_Rm, 32'hFFFF_FFFC);
    chk("t2_rs", bus.RF_Rs, 32'd4);

    // Rotated immediate, then branch, with backpressure on the branch
    run_txn(32'hE282_133C, 0);
    chk("t3_sel", 32'(bus.CTRL_select), 32'd1);
    chk("t3_rot", 32'(bus.IR_rot), 32'd3);
    run_txn(32'hEA00_0009, 5);
    chk("t4_imm", 32'(bus.IR_imm), 32'd9);

    // Illegal encoding still drains through the handshake
    run_txn(32'hEE00_0000, 2);
    chk("t5_ill", 32'(bus.op_illegal), 32'd1);
    chk("t5_sel", 32'(bus.CTRL_select), 32'd7);

    // Reset while in CAP_A drops the instruction
    chk("ra_ready", 32'(bus.instr_ready), 32'd1);
    bus.instr       = 32'hE082_1453;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("ra_capa_addr", 32'(bus.rf_addr_a), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("ra_valid", 32'(bus.op_valid), 32'd0);
    chk("ra_addr",  32'(bus.rf_addr_a), 32'd0);
    rst = 1'b0;
    #1;
    chk("ra_ready_rel", 32'(bus.instr_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ra_idle_valid", 32'(bus.op_valid), 32'd0);
      chk("ra_idle_ready", 32'(bus.instr_ready), 32'd1);
    end

    // Randomized instructions and register contents
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ins;
      for (int i = 0; i < 16; i++) regs[i] = $urandom();
`ifdef OPDEC_PC_FORWARD_EN
      pc_v = $urandom();
`endif
      ins        = $urandom();
      ins[27:25] = 3'($urandom_range(0, 7));
      run_txn(ins, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
